imem_ctrl: RTL and testbench
============================

IMEM_CTRL -- requirements
Module: imem_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 32, word width in bits; legal values are multiples of 8.
REQ-002 SHALL have parameter DEPTH, default 2048, number of words; legal values are powers of 2.
REQ-003 SHALL have parameter ADDR_W, default $clog2(DEPTH), word-address width.
REQ-004 SHALL have parameter INIT_FILE, default "" (no preload), hex image loaded into the array at elaboration.
REQ-005 SHALL have a single clock `clk`; reset is synchronous and active-low, port `reset_n`.
REQ-006 SHALL have port clk  in  1  rising-edge clock for all state.
REQ-007 SHALL have port reset_n  in  1  synchronous active-low reset.
REQ-008 SHALL have port f_req_valid  in  1  fetch request valid.
REQ-009 SHALL have port f_req_ready  out  1  fetch request accepted when high with f_req_valid.
REQ-010 SHALL have port f_req_addr  in  ADDR_W  fetch word address.
REQ-011 SHALL have port f_rsp_valid  out  1  fetch response valid.
REQ-012 SHALL have port f_rsp_ready  in  1  fetch response consumed.
REQ-013 SHALL have port f_rsp_data  out  DATA_W  fetched word.
REQ-014 SHALL have port f_rsp_err  out  1  parity error flag for f_rsp_data.
REQ-015 SHALL have port w_valid  in  1  write request valid (loader/debug port).
REQ-016 SHALL have port w_ready  out  1  write accepted.
REQ-017 SHALL have port w_addr  in  ADDR_W  write word address.
REQ-018 SHALL have port w_data  in  DATA_W  write data.
REQ-019 SHALL have port w_be  in  DATA_W/8  byte enables; bit i selects byte i.
REQ-020 SHALL have port w_poison  in  1  inverts the stored parity of byte 0 on this write (error injection).

Function
REQ-021 SHALL use one single-port array; at most one access (read or write) per cycle.
REQ-022 SHALL drive w_ready to 1 whenever out of reset; the write port has priority, so a write completes in the cycle it is presented.
REQ-023 SHALL drive f_req_ready low in any cycle with w_valid high.
REQ-024 SHALL update only bytes with w_be set; w_be=0 SHALL complete the handshake without modifying the array.
REQ-025 SHALL present read data for a fetch accepted in cycle N with f_rsp_valid in cycle N+1 (latency 1) when the response path is empty.
REQ-026 SHALL buffer responses in a 2-entry in-order FIFO; outstanding fetches (in-flight plus buffered) SHALL never exceed 2.
REQ-027 SHALL compute f_req_ready including same-cycle FIFO pop, sustaining 1 fetch/cycle while f_rsp_ready is held high.
REQ-028 SHALL hold f_rsp_data and f_rsp_err stable while f_rsp_valid=1 and f_rsp_ready=0.
REQ-029 SHALL return the new data for a fetch of an address written in any earlier cycle.
REQ-030 SHALL return responses in request order and SHALL never drop or duplicate a response.

Reset
REQ-031 SHALL drive f_rsp_valid=0, f_rsp_err=0, FIFO count=0 and in-flight flag=0 while reset_n=0 at a clock edge; f_req_ready and w_ready SHALL be 0 during reset.
REQ-032 SHALL discard any fetch in flight when reset is asserted; no response for it SHALL appear after reset.
REQ-033 SHALL NOT clear array contents on reset.

Configuration
REQ-034 SHALL, with macro IMEM_PARITY_EN defined, store one even-parity bit per byte, write it with every enabled byte (byte 0 inverted when w_poison=1), check it on read, and set f_rsp_err when any byte mismatches.
REQ-035 SHALL, without IMEM_PARITY_EN, store no parity bits, ignore w_poison, and tie f_rsp_err to 0.

Verification
REQ-036 SHALL cover: write 0x005 <- 0xDEADBEEF, be=0xF; fetch 0x005 next cycle -> f_rsp_valid one cycle after acceptance, data 0xDEADBEEF.
REQ-037 SHALL cover: write 0x010 <- 0x11223344, be=0xF; then 0xAABBCCDD, be=0b0101; fetch 0x010 -> 0x11BB33DD.
REQ-038 SHALL cover: f_rsp_ready=0 while fetching 0x000..0x003 -> exactly 2 accepted, then f_req_ready=0; raise f_rsp_ready -> all 4 words returned in order, none lost.
REQ-039 SHALL cover: w_valid and f_req_valid asserted in the same cycle -> write accepted, f_req_ready=0; fetch accepted in the next cycle and returns the written data.
REQ-040 SHALL cover: fetch accepted, reset_n=0 in the next cycle -> no f_rsp_valid after reset; a later fetch of 0x005 still returns 0xDEADBEEF.
REQ-041 SHALL cover: with IMEM_PARITY_EN, write 0x020 with w_poison=1, then fetch -> f_rsp_err=1; without the macro -> f_rsp_err=0.

Source files
------------

// File: rtl/imem_ctrl.sv
// imem_ctrl -- single-port instruction memory with a fetch port and a
// loader/debug write port.
//
// Ports:
//   clk, reset_n        : rising-edge clock, synchronous active-low reset
//   f_req_valid/ready   : fetch request handshake, f_req_addr = word address
//   f_rsp_valid/ready   : fetch response handshake, f_rsp_data / f_rsp_err
//   w_valid/ready       : write handshake (w_ready is high whenever out of reset)
//   w_addr, w_data      : write word address / data
//   w_be                : byte enables, bit i selects byte i
//   w_poison            : inverts stored parity of byte 0 (error injection)
//
// Optional feature: define IMEM_PARITY_EN to store one even-parity bit per
// byte and flag mismatches on f_rsp_err. Without it f_rsp_err is tied to 0.
//
// Writes have priority over fetches; a fetch is accepted only in a cycle
// with no write, so the array sees at most one access per cycle. Read data
// comes back one cycle after acceptance and is either consumed directly or
// parked in a 2-entry FIFO. Outstanding fetches (in flight + buffered) are
// capped at 2.
module imem_ctrl #(
  parameter int    DATA_W    = 32,
  parameter int    DEPTH     = 2048,
  parameter int    ADDR_W    = $clog2(DEPTH),
  parameter string INIT_FILE = ""
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                f_req_valid,
  output logic                f_req_ready,
  input  logic [ADDR_W-1:0]   f_req_addr,
  output logic                f_rsp_valid,
  input  logic                f_rsp_ready,
  output logic [DATA_W-1:0]   f_rsp_data,
  output logic                f_rsp_err,
  input  logic                w_valid,
  output logic                w_ready,
  input  logic [ADDR_W-1:0]   w_addr,
  input  logic [DATA_W-1:0]   w_data,
  input  logic [DATA_W/8-1:0] w_be,
  input  logic                w_poison
);
  localparam int NB = DATA_W / 8;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_data_q;
  logic              rd_err;

  logic              inflight_q, inflight_d;
  logic [1:0]        count_q, count_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic [DATA_W-1:0] fifo_data_q [2];
  logic              fifo_err_q [2];

  logic              wr_en, rd_en;
  logic              rsp_pop, fifo_pop, bypass_pop, push;
  logic [1:0]        outstanding;

  assign w_ready = reset_n;
  assign wr_en   = w_valid & reset_n;

  always_comb begin
    f_rsp_valid = reset_n & ((count_q != 2'd0) | inflight_q);
    rsp_pop     = f_rsp_valid & f_rsp_ready;
    fifo_pop    = rsp_pop & (count_q != 2'd0);
    // Fresh read data goes straight out only when nothing older is buffered.
    bypass_pop  = rsp_pop & (count_q == 2'd0);
    push        = inflight_q & ~bypass_pop;
    outstanding = count_q + {1'b0, inflight_q};
    // A same-cycle pop frees a slot, so back-to-back fetches keep flowing.
    f_req_ready = reset_n & ~w_valid & ((outstanding < 2'd2) | rsp_pop);
    rd_en       = f_req_valid & f_req_ready;

    inflight_d  = rd_en;
    count_d     = count_q + {1'b0, push} - {1'b0, fifo_pop};
    rd_ptr_d    = rd_ptr_q ^ fifo_pop;
    wr_ptr_d    = wr_ptr_q ^ push;

    if (count_q != 2'd0) begin
      f_rsp_data = fifo_data_q[rd_ptr_q];
      f_rsp_err  = f_rsp_valid & fifo_err_q[rd_ptr_q];
    end else begin
      f_rsp_data = rd_data_q;
      f_rsp_err  = f_rsp_valid & rd_err;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      inflight_q <= 1'b0;
      count_q    <= 2'd0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  // Array and data-path registers carry no reset; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < NB; i++) begin
        if (w_be[i]) mem[w_addr][8*i +: 8] <= w_data[8*i +: 8];
      end
    end
    if (rd_en) rd_data_q <= mem[f_req_addr];
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data_q[wr_ptr_q] <= rd_data_q;
      fifo_err_q[wr_ptr_q]  <= rd_err;
    end
  end

`ifdef IMEM_PARITY_EN
  logic [NB-1:0] par_mem [DEPTH];
  logic [NB-1:0] rd_par_q;

  function automatic logic parity_err(input logic [DATA_W-1:0] d,
                                      input logic [NB-1:0] p);
    logic e;
    e = 1'b0;
    for (int i = 0; i < NB; i++) e |= ((^d[8*i +: 8]) != p[i]);
    return e;
  endfunction

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < NB; i++) begin
        if (w_be[i]) par_mem[w_addr][i] <= (^w_data[8*i +: 8]) ^ ((i == 0) & w_poison);
      end
    end
    if (rd_en) rd_par_q <= par_mem[f_req_addr];
  end

  assign rd_err = parity_err(rd_data_q, rd_par_q);
`else
  logic unused_poison;
  assign unused_poison = w_poison;
  assign rd_err        = 1'b0;
`endif

endmodule

// File: tb/tb_imem_ctrl.sv
module tb_imem_ctrl;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 64;
  localparam int ADDR_W = 6;
  localparam int NB     = DATA_W / 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset_n, f_req_valid, f_req_ready, f_rsp_valid, f_rsp_ready;
  logic [ADDR_W-1:0] f_req_addr, w_addr;
  logic [DATA_W-1:0] f_rsp_data, w_data;
  logic              f_rsp_err, w_valid, w_ready, w_poison;
  logic [NB-1:0]     w_be;

  imem_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .f_req_valid(f_req_valid), .f_req_ready(f_req_ready), .f_req_addr(f_req_addr),
    .f_rsp_valid(f_rsp_valid), .f_rsp_ready(f_rsp_ready), .f_rsp_data(f_rsp_data),
    .f_rsp_err(f_rsp_err), .w_valid(w_valid), .w_ready(w_ready), .w_addr(w_addr),
    .w_data(w_data), .w_be(w_be), .w_poison(w_poison));

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              err;
  } rsp_t;

  int checks = 0;
  int failures = 0;
  logic [DATA_W-1:0] shadow [DEPTH];
  logic              poison0 [DEPTH];
  rsp_t              expq[$];
  logic [DATA_W-1:0] poplog[$];
  logic [DATA_W-1:0] last_data;
  logic              last_err;
  logic              par_en;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic idle();
    f_req_valid = 1'b0; f_req_addr = '0; f_rsp_ready = 1'b1;
    w_valid = 1'b0; w_addr = '0; w_data = '0; w_be = '0; w_poison = 1'b0;
  endtask

  // One clock: check outputs against the model mid-cycle, advance the model
  // with what the edge will commit, then move to the next falling edge.
  task automatic step();
    bit   pop;
    logic exp_rdy, exp_vld;
    rsp_t r;
    #2;
    exp_vld = reset_n && (expq.size() > 0);
    pop     = exp_vld && f_rsp_ready;
    exp_rdy = reset_n && !w_valid && ((expq.size() - int'(pop)) < 2);
    chk("w_ready", w_ready, reset_n);
    chk("f_req_ready", f_req_ready, exp_rdy);
    chk("f_rsp_valid", f_rsp_valid, exp_vld);
    if (exp_vld) begin
      chk("f_rsp_data", f_rsp_data, expq[0].data);
      chk("f_rsp_err", f_rsp_err, expq[0].err);
    end else begin
      chk("f_rsp_err_idle", f_rsp_err, 1'b0);
    end
    if (!reset_n) begin
      expq.delete();
    end else begin
      if (pop) begin
        r = expq.pop_front();
        last_data = r.data;
        last_err  = r.err;
        poplog.push_back(r.data);
      end
      if (w_valid) begin
        for (int i = 0; i < NB; i++)
          if (w_be[i]) shadow[w_addr][8*i +: 8] = w_data[8*i +: 8];
        if (w_be[0]) poison0[w_addr] = w_poison;
      end
      if (f_req_valid && f_req_ready) begin
        r.data = shadow[f_req_addr];
        r.err  = par_en && poison0[f_req_addr];
        expq.push_back(r);
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                       input logic [NB-1:0] be, input logic poison);
    idle();
    w_valid = 1'b1; w_addr = a; w_data = d; w_be = be; w_poison = poison;
    step();
    idle();
  endtask

  task automatic fetch_and_get(input logic [ADDR_W-1:0] a);
    idle();
    f_req_valid = 1'b1; f_req_addr = a;
    step();
    idle();
    step();
  endtask

  initial begin
    int issued, accepted, pops_before;
    bit acc;
`ifdef IMEM_PARITY_EN
    par_en = 1'b1;
`else
    par_en = 1'b0;
`endif
    last_data = '0; last_err = 1'b0;
    idle();
    reset_n = 1'b0;
    step();
    step();
    chk("rst_valid", f_rsp_valid, 1'b0);
    reset_n = 1'b1;

    for (int a = 0; a < DEPTH; a++) write(a[ADDR_W-1:0], $urandom, 4'hF, 1'b0);

    // Full write then fetch: response one cycle after acceptance.
    write(6'h05, 32'hDEADBEEF, 4'hF, 1'b0);
    idle(); f_req_valid = 1'b1; f_req_addr = 6'h05; f_rsp_ready = 1'b0;
    step();
    idle(); f_rsp_ready = 1'b0;
    chk("t036_latency", f_rsp_valid, 1'b1);
    f_rsp_ready = 1'b1;
    step();
    chk("t036_data", last_data, 32'hDEADBEEF);

    // Partial byte-enable merge.
    write(6'h10, 32'h11223344, 4'hF, 1'b0);
    write(6'h10, 32'hAABBCCDD, 4'b0101, 1'b0);
    fetch_and_get(6'h10);
    chk("t037_merge", last_data, 32'h11BB33DD);

    // Backpressure: only two outstanding, then all four drain in order.
    for (int i = 0; i < 4; i++) write(i[ADDR_W-1:0], 32'hA0 + i, 4'hF, 1'b0);
    poplog.delete();
    issued = 0; accepted = 0;
    for (int c = 0; c < 4; c++) begin
      idle(); f_rsp_ready = 1'b0; f_req_valid = 1'b1; f_req_addr = issued[ADDR_W-1:0];
      #1 acc = f_req_ready;
      step();
      if (acc) begin issued++; accepted++; end
    end
    chk("t038_accepted", accepted, 2);
    idle(); f_rsp_ready = 1'b0; f_req_valid = 1'b1; f_req_addr = 6'h02;
    #1 chk("t038_stall_ready", f_req_ready, 1'b0);
    for (int c = 0; c < 20 && poplog.size() < 4; c++) begin
      idle();
      if (issued < 4) begin f_req_valid = 1'b1; f_req_addr = issued[ADDR_W-1:0]; end
      #1 acc = f_req_valid && f_req_ready;
      step();
      if (acc) issued++;
    end
    chk("t038_count", poplog.size(), 4);
    for (int i = 0; i < 4; i++)
      chk("t038_order", (i < poplog.size()) ? poplog[i] : 32'hX, 32'hA0 + i);

    // Write and fetch in the same cycle: write wins, fetch follows.
    idle();
    w_valid = 1'b1; w_addr = 6'h30; w_data = 32'h12345678; w_be = 4'hF;
    f_req_valid = 1'b1; f_req_addr = 6'h30;
    #1 chk("t039_ready_low", f_req_ready, 1'b0);
    step();
    idle(); f_req_valid = 1'b1; f_req_addr = 6'h30;
    #1 chk("t039_ready_next", f_req_ready, 1'b1);
    step();
    idle();
    step();
    chk("t039_data", last_data, 32'h12345678);

    // Reset discards the fetch in flight; contents survive.
    idle(); f_req_valid = 1'b1; f_req_addr = 6'h05;
    step();
    pops_before = poplog.size();
    idle(); reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    for (int c = 0; c < 3; c++) step();
    chk("t040_no_rsp", poplog.size(), pops_before);
    fetch_and_get(6'h05);
    chk("t040_data", last_data, 32'hDEADBEEF);

    // Poisoned write.
    write(6'h20, 32'h0F0F0F0F, 4'hF, 1'b1);
    fetch_and_get(6'h20);
    chk("t041_err", last_err, par_en);
    chk("t041_data", last_data, 32'h0F0F0F0F);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      reset_n     = ($urandom_range(0, 99) != 0);
      w_valid     = ($urandom_range(0, 3) == 0);
      w_addr      = $urandom_range(0, DEPTH - 1);
      w_data      = $urandom;
      w_be        = $urandom;
      w_poison    = ($urandom_range(0, 7) == 0);
      f_req_valid = ($urandom_range(0, 9) < 6);
      f_req_addr  = $urandom_range(0, DEPTH - 1);
      f_rsp_ready = ($urandom_range(0, 9) < 7);
      step();
    end
    reset_n = 1'b1;
    idle();
    for (int c = 0; c < 10; c++) step();
    chk("drain_empty", expq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
